ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 16, memory word-address width.
REQ-002 Parameter DW, default 16, memory data width.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  3  per-requester request; bit0 loader, bit1 cpu data, bit2 cpu fetch.
REQ-006 we  input  3  per-requester write enable, qualified by req.
REQ-007 addr0/addr1/addr2  input  AW each  per-requester word address.
REQ-008 wdata0/wdata1/wdata2  input  DW each  per-requester write data.
REQ-009 ack  output  3  one-hot, one-cycle completion pulse to granted requester.
REQ-010 rdata  output  DW  read data, valid only in the ack cycle of a read.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 mem_addr  output  AW  RAM address, registered.
REQ-013 mem_we  output  1  RAM write strobe, registered.
REQ-014 mem_wdata  output  DW  RAM write data, registered.
REQ-015 mem_rdata  input  DW  RAM read data, one-cycle synchronous-read latency.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req bit set, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-017 In IDLE the arbiter samples req and selects one requester round-robin, searching from (last_grant+1) mod 3 upward.
REQ-018 On IDLE->ACCESS, grant index, addr, we and wdata of the winner are latched; later changes to that requester's inputs are ignored until ack.
REQ-019 In ACCESS, mem_addr/mem_wdata carry the latched values and mem_we equals the latched we, for exactly one cycle.
REQ-020 mem_we is 0 in every state except ACCESS.
REQ-021 In RESP, ack[grant] is 1 for exactly one cycle, and rdata equals mem_rdata for reads; rdata holds its last value otherwise.
REQ-022 Writes also complete through RESP with ack, giving uniform latency: req sampled in cycle N -> ack in cycle N+2.
REQ-023 last_grant updates to the granted index on IDLE->ACCESS.
REQ-024 A requester still holding req in its ack cycle is treated as a new request at the next IDLE sample; requesters drop req on the edge after ack.
REQ-025 Requests not granted stay pending by holding req; no request is queued internally.
REQ-026 Maximum wait for a continuously asserting requester: two other accesses (6 cycles) before grant.
REQ-027 Peak throughput: one access per 3 cycles.

Reset
REQ-028 On reset: state IDLE, ack 0, busy 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, last_grant 2 (so loader wins first).
REQ-029 Reset in ACCESS or RESP aborts the access: no ack issued, mem_we 0 in the following cycle.

Structure
REQ-030 Package ram_arb_pkg holds the state enumeration, requester index constants (REQ_LOADER=0, REQ_DATA=1, REQ_FETCH=2) and NREQ=3.
REQ-031 Round-robin selection lives in one combinational sub-module rr_pick (inputs req, last_grant; outputs grant index, valid).

Verification
REQ-032 Single read: req=3'b010, addr1=16'h0004, RAM[4]=16'h1234 -> mem_addr=16'h0004 in N+1, ack=3'b010 and rdata=16'h1234 in N+2.
REQ-033 Single write: req=3'b001, we=3'b001, addr0=16'h0008, wdata0=16'hBEEF -> mem_we=1 only in N+1, ack=3'b001 in N+2, then RAM[8] reads back 16'hBEEF.
REQ-034 Simultaneous req=3'b111 held after reset -> grant order loader, data, fetch, loader; acks 3 cycles apart.
REQ-035 Continuous fetch req plus data req from cycle 1 -> data granted no later than the second arbitration; fetch never starved.
REQ-036 Input change in ACCESS: addr1 switched 16'h0004->16'h0005 after grant -> mem_addr stays 16'h0004.
REQ-037 Reset asserted in ACCESS of a write -> no ack, mem_we 0 next cycle, busy 0, next grant goes to loader.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and constants for the three-port RAM arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    localparam int NREQ = 3;

    localparam logic [1:0] REQ_LOADER = 2'd0;
    localparam logic [1:0] REQ_DATA   = 2'd1;
    localparam logic [1:0] REQ_FETCH  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin pick starting after the last grant.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import ram_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      last_grant_i,
    output logic [1:0]      grant_o,
    output logic            valid_o
);

    // Scan from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        grant_o = last_grant_i;
        valid_o = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            int cand;
            cand = (int'(last_grant_i) + k) % NREQ;
            if (req_i[cand]) begin
                grant_o = cand[1:0];
                valid_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module      : ram_arbiter
// Description : Three-requester round-robin arbiter for a synchronous RAM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [AW-1:0]   addr2,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW-1:0]   wdata1,
    input  logic [DW-1:0]   wdata2,
    output logic [2:0]      ack,
    output logic [DW-1:0]   rdata,
    output logic            busy,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    state_t          state_q, state_d;
    logic [1:0]      grant_q;
    logic [1:0]      last_grant_q;
    logic            we_q;
    logic [AW-1:0]   mem_addr_q;
    logic            mem_we_q;
    logic [DW-1:0]   mem_wdata_q;
    logic [2:0]      ack_q;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic [1:0]      pick_grant;
    logic            pick_valid;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_we;

    rr_pick u_rr_pick (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_grant),
        .valid_o      (pick_valid)
    );

    always_comb begin
        sel_addr  = addr0;
        sel_wdata = wdata0;
        sel_we    = we[0];
        case (pick_grant)
            REQ_DATA: begin
                sel_addr  = addr1;
                sel_wdata = wdata1;
                sel_we    = we[1];
            end
            REQ_FETCH: begin
                sel_addr  = addr2;
                sel_wdata = wdata2;
                sel_we    = we[2];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (pick_valid) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // RAM data arrives in RESP; outside a read response the last value is held.
    always_comb begin
        rdata_d = rdata_q;
        if (state_q == ST_RESP && !we_q) begin
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= REQ_LOADER;
            last_grant_q <= REQ_FETCH;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            ack_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q  <= state_d;
            mem_we_q <= 1'b0;
            ack_q    <= '0;
            rdata_q  <= rdata_d;
            if (state_q == ST_IDLE && pick_valid) begin
                grant_q      <= pick_grant;
                last_grant_q <= pick_grant;
                we_q         <= sel_we;
                mem_addr_q   <= sel_addr;
                mem_wdata_q  <= sel_wdata;
                mem_we_q     <= sel_we;
            end
            if (state_q == ST_ACCESS) begin
                ack_q <= idx_to_onehot(grant_q);
            end
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_d;
    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed and randomized checks of ram_arbiter against a model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req, we;
    logic [15:0] addr0, addr1, addr2;
    logic [15:0] wdata0, wdata1, wdata2;
    logic [2:0]  ack;
    logic [15:0] rdata;
    logic        busy;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic        init_ram, poke_en;
    logic [7:0]  poke_a;
    logic [15:0] poke_d;
    logic [15:0] ram  [256];
    logic [15:0] mram [256];

    int n_checks = 0;
    int n_fail   = 0;

    ram_arbiter #(.AW(16), .DW(16)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .ack(ack), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 257) ^ 16'hA5C3;
    endfunction

    // Synchronous-read RAM with one-cycle latency.
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 256; i++) ram[i] <= pat(i);
        end else if (poke_en) begin
            ram[poke_a] <= poke_d;
        end
        if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 3'b000;
        we    = 3'b000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int rr_model(input logic [2:0] pend, input int last);
        for (int o = 1; o <= 3; o++) begin
            if (pend[(last + o) % 3]) return (last + o) % 3;
        end
        return last;
    endfunction

    // Requester-side state for the random phase.
    logic [2:0]  pend;
    logic [15:0] ra [3];
    logic        rw [3];
    logic [15:0] rd [3];
    int          others [3];

    task automatic drive_inputs();
        req    = pend;
        we     = {rw[2], rw[1], rw[0]};
        addr0  = ra[0]; addr1  = ra[1]; addr2  = ra[2];
        wdata0 = rd[0]; wdata1 = rd[1]; wdata2 = rd[2];
    endtask

    initial begin
        int          exp_at, exp_idx, last, next_s;
        logic        exp_we;
        logic [15:0] exp_rd, last_rd;
        logic [2:0]  exp_ack;

        reset = 1'b1; req = '0; we = '0;
        addr0 = '0; addr1 = '0; addr2 = '0;
        wdata0 = '0; wdata1 = '0; wdata2 = '0;
        init_ram = 1'b1; poke_en = 1'b0; poke_a = '0; poke_d = '0;

        @(negedge clk);
        init_ram = 1'b0;
        poke_en = 1'b1; poke_a = 8'd4; poke_d = 16'h1234;
        @(negedge clk);
        poke_a = 8'd5; poke_d = 16'h5555;
        @(negedge clk);
        poke_en = 1'b0;

        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        reset = 1'b0;

        // Single read, with the requester's address changing after grant
        req = 3'b010; addr1 = 16'h0004;
        @(negedge clk);
        chk("rd_mem_addr", 32'(mem_addr), 32'h0004);
        chk("rd_mem_we", 32'(mem_we), 32'h0);
        chk("rd_busy", 32'(busy), 32'h1);
        addr1 = 16'h0005;
        @(negedge clk);
        chk("rd_ack", 32'(ack), 32'h2);
        chk("rd_rdata", 32'(rdata), 32'h1234);
        chk("rd_addr_held", 32'(mem_addr), 32'h0004);
        req = 3'b000;
        @(negedge clk);
        chk("rd_ack_clear", 32'(ack), 32'h0);
        chk("rd_idle", 32'(busy), 32'h0);
        chk("rd_hold", 32'(rdata), 32'h1234);

        // Single write followed by read-back
        req = 3'b001; we = 3'b001; addr0 = 16'h0008; wdata0 = 16'hBEEF;
        @(negedge clk);
        chk("wr_mem_we", 32'(mem_we), 32'h1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h0008);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        @(negedge clk);
        chk("wr_ack", 32'(ack), 32'h1);
        chk("wr_mem_we_off", 32'(mem_we), 32'h0);
        chk("wr_rdata_hold", 32'(rdata), 32'h1234);
        req = 3'b000; we = 3'b000;
        @(negedge clk);
        chk("wr_idle_we", 32'(mem_we), 32'h0);
        req = 3'b010; addr1 = 16'h0008;
        @(negedge clk);
        @(negedge clk);
        chk("rb_ack", 32'(ack), 32'h2);
        chk("rb_rdata", 32'(rdata), 32'hBEEF);
        req = 3'b000;

        // All three requesting continuously after reset
        do_reset();
        req = 3'b111;
        for (int t = 1; t <= 11; t++) begin
            logic [2:0] e;
            @(negedge clk);
            e = 3'b000;
            if (t == 2 || t == 11) e = 3'b001;
            if (t == 5) e = 3'b010;
            if (t == 8) e = 3'b100;
            chk($sformatf("all3_ack_t%0d", t), 32'(ack), 32'(e));
        end
        req = 3'b000;

        // Continuous fetch, data joining one cycle later
        do_reset();
        req = 3'b100;
        @(negedge clk);
        chk("fd_ack_t1", 32'(ack), 32'h0);
        req = 3'b110;
        for (int t = 2; t <= 8; t++) begin
            logic [2:0] e;
            @(negedge clk);
            e = 3'b000;
            if (t == 2 || t == 8) e = 3'b100;
            if (t == 5) e = 3'b010;
            chk($sformatf("fd_ack_t%0d", t), 32'(ack), 32'(e));
        end
        req = 3'b000;
        @(negedge clk);

        // Reset during ACCESS of a loader write
        req = 3'b001; we = 3'b001; addr0 = 16'h0009; wdata0 = 16'hCAFE;
        @(negedge clk);
        chk("ab_mem_we", 32'(mem_we), 32'h1);
        reset = 1'b1; req = 3'b000; we = 3'b000;
        @(negedge clk);
        chk("ab_ack", 32'(ack), 32'h0);
        chk("ab_mem_we_off", 32'(mem_we), 32'h0);
        chk("ab_busy", 32'(busy), 32'h0);
        reset = 1'b0; req = 3'b011;
        @(negedge clk);
        @(negedge clk);
        chk("ab_next_grant", 32'(ack), 32'h1);
        req = 3'b000;

        // Randomized traffic against the transaction-level model
        @(negedge clk);
        init_ram = 1'b1;
        do_reset();
        init_ram = 1'b0;
        for (int i = 0; i < 256; i++) mram[i] = pat(i);
        pend = '0;
        for (int i = 0; i < 3; i++) begin
            ra[i] = '0; rw[i] = 1'b0; rd[i] = '0; others[i] = 0;
        end
        exp_at = -10; exp_idx = 0; exp_we = 1'b0; exp_rd = '0; last_rd = '0;
        last = 2; next_s = 1;

        for (int k = 0; k < 3000; k++) begin
            if (k > 0) @(negedge clk);

            if (k == exp_at) begin
                exp_ack = 3'b001 << exp_idx;
                chk("rnd_ack", 32'(ack), 32'(exp_ack));
                if (!exp_we) begin
                    chk("rnd_rdata", 32'(rdata), 32'(exp_rd));
                    last_rd = exp_rd;
                end else begin
                    chk("rnd_rdata_hold", 32'(rdata), 32'(last_rd));
                end
                pend[exp_idx] = 1'b0;
            end else begin
                chk("rnd_ack_idle", 32'(ack), 32'h0);
            end
            chk("rnd_busy", 32'(busy), 32'(k == exp_at || k == exp_at - 1));

            // The winner's inputs wander while its access is in flight.
            if (k == exp_at - 1) begin
                ra[exp_idx] = 16'($urandom_range(0, 15));
                rd[exp_idx] = 16'($urandom);
            end

            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]   = 1'b1;
                    ra[i]     = 16'($urandom_range(0, 15));
                    rw[i]     = 1'($urandom_range(0, 1));
                    rd[i]     = 16'($urandom);
                    others[i] = 0;
                end
            end
            drive_inputs();

            if (k + 1 >= next_s && pend != 3'b000) begin
                int win;
                win     = rr_model(pend, last);
                exp_at  = k + 2;
                exp_idx = win;
                exp_we  = rw[win];
                if (rw[win]) mram[ra[win][7:0]] = rd[win];
                else         exp_rd = mram[ra[win][7:0]];
                for (int j = 0; j < 3; j++) begin
                    if (j != win && pend[j]) begin
                        others[j]++;
                        chk("rnd_wait_bound", 32'(others[j] <= 2), 32'h1);
                    end
                end
                others[win] = 0;
                last   = win;
                next_s = k + 4;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
